// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, PCSrc encodings, IR field positions and fetch FSM states
package cpu_pkg;
  localparam logic [5:0] OP_NOOP = 6'b000000;
  localparam logic [5:0] OP_JUMP = 6'b000001;
  localparam logic [5:0] OP_BEQ  = 6'b100000;
  localparam logic [5:0] OP_BNE  = 6'b100001;
  localparam logic [3:0] OP_RTYPE_PFX = 4'b0100;
  localparam logic [1:0] OP_ITYPE_PFX = 2'b11;
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_HOLD   = 2'b11
  } pcsrc_e;
  typedef enum logic {S_IDLE, S_WAIT} fetch_state_e;
  function automatic logic is_rtype(input logic [5:0] op);
    return op[5:2] == OP_RTYPE_PFX;
  endfunction
  function automatic logic is_itype(input logic [5:0] op);
    return op[5:4] == OP_ITYPE_PFX;
  endfunction
endpackage

// File: rtl/next_pc_sel.sv
// next_pc_sel: PCSrc mux and branch-condition evaluation producing next_pc and pc_we
module next_pc_sel
  import cpu_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0] i_pc,
  input  logic [PC_W-1:0] i_alu_result,
  input  logic [PC_W-1:0] i_alu_out,
  input  logic [PC_W-1:0] i_jump_tgt,
  input  logic [1:0]      i_pc_src,
  input  logic            i_pc_write,
  input  logic            i_pc_write_cond,
  input  logic            i_beq,
  input  logic            i_alu_zero,
  output logic [PC_W-1:0] o_next_pc,
  output logic            o_pc_we
);
  // Select next PC; a conditional write fires on zero for BEQ, non-zero for BNE
  always_comb begin
    o_next_pc = (i_pc_src == PCSRC_ALU)    ? i_alu_result :
                (i_pc_src == PCSRC_ALUOUT) ? i_alu_out    :
                (i_pc_src == PCSRC_JUMP)   ? i_jump_tgt   : i_pc;
    o_pc_we   = i_pc_write | (i_pc_write_cond & (i_beq ? i_alu_zero : ~i_alu_zero));
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR stage with valid/request instruction fetch; FETCH_TIMEOUT_EN adds a fetch watchdog
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            PCWrite_ctrl,
  input  logic            PCWriteCond_ctrl,
  input  logic            BEQ_ctrl,
  input  logic [1:0]      PCSrc_ctrl,
  input  logic            IRWrite_ctrl,
  input  logic [PC_W-1:0] alu_result,
  input  logic [PC_W-1:0] alu_out,
  input  logic            alu_zero,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     ir,
  output logic [5:0]      opcode,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [15:0]     imm,
  output logic            stall,
  output logic            fetch_err
);
  fetch_state_e    r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_ir;
  logic [PC_W-1:0] w_next_pc;
  logic            w_pc_we;
  logic            w_done;
  logic            w_timeout;
  logic            w_pc_upd;

  next_pc_sel #(.PC_W(PC_W)) u_next_pc_sel (
    .i_pc            (r_pc),
    .i_alu_result    (alu_result),
    .i_alu_out       (alu_out),
    .i_jump_tgt      (PC_W'(r_ir)),
    .i_pc_src        (PCSrc_ctrl),
    .i_pc_write      (PCWrite_ctrl),
    .i_pc_write_cond (PCWriteCond_ctrl),
    .i_beq           (BEQ_ctrl),
    .i_alu_zero      (alu_zero),
    .o_next_pc       (w_next_pc),
    .o_pc_we         (w_pc_we)
  );

  // Request is live while waiting or when a fetch is asked for; PC writes are deferred to IR latch
  always_comb begin
    imem_req    = (r_state == S_WAIT) | IRWrite_ctrl;
    w_done      = imem_req & (imem_valid | w_timeout);
    w_state_nxt = (imem_req & ~w_done) ? S_WAIT : S_IDLE;
    stall       = imem_req & ~w_done;
    w_pc_upd    = w_pc_we & (w_done | ~imem_req);
  end

  // State, PC and IR registers; reset discards any outstanding fetch
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pc_upd) r_pc <= w_next_pc;
      if (w_done) r_ir <= imem_valid ? imem_rdata : '0;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  assign w_timeout = (r_state == S_WAIT) & ~imem_valid & (r_cnt == CNT_W'(TIMEOUT - 1));
  assign fetch_err = r_err;
  // Watchdog counts WAIT cycles; a timeout completes the fetch as a NOOP and sets a sticky error
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (r_state == S_WAIT && !w_done) ? r_cnt + 1'b1 : '0;
      r_err <= r_err | w_timeout;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign fetch_err = 1'b0;
`endif

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign ir        = r_ir;
  assign opcode    = r_ir[OP_HI:OP_LO];
  assign rs        = r_ir[RS_HI:RS_LO];
  assign rt        = r_ir[RT_HI:RT_LO];
  assign rd        = r_ir[RD_HI:RD_LO];
  assign imm       = r_ir[IMM_HI:IMM_LO];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        PCWrite_ctrl = 1'b0, PCWriteCond_ctrl = 1'b0, BEQ_ctrl = 1'b0, IRWrite_ctrl = 1'b0;
  logic [1:0]  PCSrc_ctrl = 2'b00;
  logic [15:0] alu_result = '0, alu_out = '0;
  logic        alu_zero = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic [15:0] pc;
  logic [31:0] ir;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        stall, fetch_err;
  int          tests = 0;
  int          fails = 0;

  fetch_unit #(.PC_W(16), .RESET_PC(16'h0000), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .PCWrite_ctrl(PCWrite_ctrl), .PCWriteCond_ctrl(PCWriteCond_ctrl), .BEQ_ctrl(BEQ_ctrl),
    .PCSrc_ctrl(PCSrc_ctrl), .IRWrite_ctrl(IRWrite_ctrl),
    .alu_result(alu_result), .alu_out(alu_out), .alu_zero(alu_zero),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .pc(pc), .ir(ir), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .stall(stall), .fetch_err(fetch_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_err", 32'(fetch_err), 32'h0);
    reset = 1'b1;
    IRWrite_ctrl = 1'b1; PCWrite_ctrl = 1'b1; PCSrc_ctrl = 2'b00; alu_result = 16'h0001;
    settle();
    chk("f1_stall_c0", 32'(stall), 32'h1);
    chk("f1_req_c0", 32'(imem_req), 32'h1);
    chk("f1_addr_c0", 32'(imem_addr), 32'h0);
    tick();
    chk("f1_stall_c1", 32'(stall), 32'h1);
    chk("f1_addr_c1", 32'(imem_addr), 32'h0);
    chk("f1_pc_held", 32'(pc), 32'h0);
    tick();
    imem_valid = 1'b1; imem_rdata = 32'h4800_0000;
    settle();
    chk("f1_stall_done", 32'(stall), 32'h0);
    chk("f1_addr_c2", 32'(imem_addr), 32'h0);
    tick();
    IRWrite_ctrl = 1'b0; PCWrite_ctrl = 1'b0; imem_valid = 1'b0;
    settle();
    chk("f1_ir", ir, 32'h4800_0000);
    chk("f1_opcode", 32'(opcode), 32'b010010);
    chk("f1_pc", 32'(pc), 32'h1);
    chk("f1_req_off", 32'(imem_req), 32'h0);
    IRWrite_ctrl = 1'b1; PCWrite_ctrl = 1'b1; alu_result = 16'h0002;
    imem_valid = 1'b1; imem_rdata = 32'h8C4A_1234;
    settle();
    chk("zw_stall", 32'(stall), 32'h0);
    chk("zw_addr", 32'(imem_addr), 32'h1);
    tick();
    IRWrite_ctrl = 1'b0; PCWrite_ctrl = 1'b0; imem_valid = 1'b0;
    chk("zw_ir", ir, 32'h8C4A_1234);
    chk("zw_pc", 32'(pc), 32'h2);
    chk("zw_opcode", 32'(opcode), 32'b100011);
    chk("zw_rs", 32'(rs), 32'd2);
    chk("zw_rt", 32'(rt), 32'd10);
    chk("zw_rd", 32'(rd), 32'd2);
    chk("zw_imm", 32'(imm), 32'h1234);
    imem_valid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    imem_valid = 1'b0;
    chk("spur_ir", ir, 32'h8C4A_1234);
    chk("spur_pc", 32'(pc), 32'h2);
    PCWriteCond_ctrl = 1'b1; BEQ_ctrl = 1'b1; alu_zero = 1'b1; PCSrc_ctrl = 2'b01; alu_out = 16'h0020;
    tick();
    chk("beq_taken", 32'(pc), 32'h20);
    alu_zero = 1'b0; alu_out = 16'h0030;
    tick();
    chk("beq_not_taken", 32'(pc), 32'h20);
    BEQ_ctrl = 1'b0; alu_out = 16'h0040;
    tick();
    chk("bne_taken", 32'(pc), 32'h40);
    alu_zero = 1'b1; alu_out = 16'h0050;
    tick();
    chk("bne_not_taken", 32'(pc), 32'h40);
    PCWriteCond_ctrl = 1'b0; PCWrite_ctrl = 1'b1; PCSrc_ctrl = 2'b11;
    tick();
    chk("hold_src", 32'(pc), 32'h40);
    PCWrite_ctrl = 1'b0; IRWrite_ctrl = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h0400_00FF;
    tick();
    IRWrite_ctrl = 1'b0; imem_valid = 1'b0;
    chk("jmp_ir", ir, 32'h0400_00FF);
    chk("jmp_opcode", 32'(opcode), 32'b000001);
    chk("jmp_pc_pre", 32'(pc), 32'h40);
    PCWrite_ctrl = 1'b1; PCSrc_ctrl = 2'b10;
    tick();
    chk("jmp_pc", 32'(pc), 32'hFF);
    PCSrc_ctrl = 2'b00; alu_result = 16'h1234; IRWrite_ctrl = 1'b1;
    tick();
    chk("gate_pc", 32'(pc), 32'hFF);
    chk("gate_stall", 32'(stall), 32'h1);
    tick();
    reset = 1'b0; IRWrite_ctrl = 1'b0; PCWrite_ctrl = 1'b0;
    tick();
    chk("rw_pc", 32'(pc), 32'h0);
    chk("rw_stall", 32'(stall), 32'h0);
    chk("rw_req", 32'(imem_req), 32'h0);
    reset = 1'b1; imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_valid = 1'b0;
    chk("late_ir", ir, 32'h0);
    chk("late_pc", 32'(pc), 32'h0);
    PCWrite_ctrl = 1'b1; alu_result = 16'hFFFF;
    tick();
    alu_result = 16'h0000;
    tick();
    chk("wrap_pc", 32'(pc), 32'h0);
    PCWrite_ctrl = 1'b0; IRWrite_ctrl = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_valid = 1'b0;
    PCWrite_ctrl = 1'b1; alu_result = 16'h0005;
`ifdef FETCH_TIMEOUT_EN
    begin
      int n;
      n = 0;
      tick();
      while (imem_req && n < 40) begin
        tick();
        n++;
      end
      IRWrite_ctrl = 1'b0; PCWrite_ctrl = 1'b0;
      chk("to_finished", 32'(n < 40), 32'h1);
      chk("to_ir", ir, 32'h0);
      chk("to_opcode", 32'(opcode), 32'h0);
      chk("to_err", 32'(fetch_err), 32'h1);
      chk("to_pc", 32'(pc), 32'h5);
      tick();
      tick();
      chk("to_err_sticky", 32'(fetch_err), 32'h1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("to_err_clr", 32'(fetch_err), 32'h0);
    end
`else
    for (int i = 0; i < 20; i++) tick();
    chk("nto_stall", 32'(stall), 32'h1);
    chk("nto_req", 32'(imem_req), 32'h1);
    chk("nto_err", 32'(fetch_err), 32'h0);
    chk("nto_pc", 32'(pc), 32'h0);
    imem_valid = 1'b1; imem_rdata = 32'hC000_0001;
    tick();
    imem_valid = 1'b0; IRWrite_ctrl = 1'b0; PCWrite_ctrl = 1'b0;
    chk("nto_ir", ir, 32'hC000_0001);
    chk("nto_pc_done", 32'(pc), 32'h5);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- PC/IR datapath stage directly upstream of the multicycle Controller.
- Holds the program counter and instruction register, and fetches instructions from instruction memory through a valid/request handshake.
- Drives the 6-bit opcode into the Controller's Instruction_ctrlIn.
- Applies the Controller's PCWrite/PCWriteCond/BEQ/PCSrc/IRWrite decisions; raises stall while a fetch is outstanding.

Parameters:
- PC_W, 16: program counter width (word address).
- RESET_PC, 0: PC value after reset.
- TIMEOUT, 15: fetch watchdog limit in cycles (used only with FETCH_TIMEOUT_EN).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- PCWrite_ctrl  in  1  unconditional PC write
- PCWriteCond_ctrl  in  1  conditional (branch) PC write
- BEQ_ctrl  in  1  1 = branch on zero (BEQ), 0 = branch on non-zero (BNE)
- PCSrc_ctrl  in  2  next-PC select
- IRWrite_ctrl  in  1  request a fetch into IR
- alu_result  in  PC_W  ALU combinational result (PC+1)
- alu_out  in  PC_W  registered ALUOut (branch target)
- alu_zero  in  1  ALU zero flag
- imem_addr  out  PC_W  fetch address
- imem_req  out  1  fetch request
- imem_rdata  in  32  instruction word
- imem_valid  in  1  imem_rdata valid this cycle
- pc  out  PC_W  current PC
- ir  out  32  instruction register
- opcode  out  6  ir[31:26], to Controller Instruction_ctrlIn
- rs, rt, rd  out  5 each  ir[25:21], ir[20:16], ir[15:11]
- imm  out  16  ir[15:0]
- stall  out  1  freeze Controller state advance
- fetch_err  out  1  sticky watchdog error (0 when feature absent)

Behaviour:
- Reset (reset==0 at posedge):
  - pc=RESET_PC, ir=0 (NOOP opcode 000000).
  - imem_req=0, stall=0, fetch_err=0, FSM=IDLE.
  - Reset overrides an outstanding fetch; a late imem_valid after reset is ignored.
- PCSrc encoding:
  - 00: alu_result
  - 01: alu_out
  - 10: {pc[PC_W-1:PC_W-?] unused}, i.e. ir[PC_W-1:0], the jump target, zero-extended/truncated to PC_W
  - 11: hold current pc
- pc_we = PCWrite_ctrl | (PCWriteCond_ctrl & (BEQ_ctrl ? alu_zero : ~alu_zero)).
- FSM IDLE:
  - IRWrite_ctrl=1 -> imem_req=1, imem_addr=pc; go to WAIT.
  - stall is combinationally 1 in this cycle unless imem_valid is also 1 (zero-wait memory).
- FSM WAIT:
  - Hold imem_req=1, imem_addr stable, stall=1.
  - On imem_valid: ir<=imem_rdata; apply pc_we in that same edge; stall=0; return to IDLE.
- Fetch-cycle PC update:
  - In the fetch cycle (IRWrite_ctrl=1), the PC update is deferred until IR latches.
  - imem_addr therefore always reflects the pre-increment PC.
- Non-fetch cycles (IDLE, IRWrite_ctrl=0): pc<=next_pc when pc_we=1; ir holds.
- Stall gating: no pc or ir write while stall=1.
- Zero-wait case (IDLE, IRWrite_ctrl=1, imem_valid=1 same cycle): latch IR and PC in one cycle; FSM stays in IDLE.
- Spurious imem_valid in IDLE without IRWrite_ctrl: ignored.
- Wrap-around: PC arithmetic is modulo 2^PC_W; fetch_unit performs no addition itself.
- Field outputs are pure slices of ir; opcode changes only on the cycle after an IR latch.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT.
  - If it reaches TIMEOUT with no imem_valid: ir<=0 (NOOP), fetch_err<=1 (sticky until reset), pc advances as if the fetch completed, FSM->IDLE, imem_req drops.
- When undefined: WAIT lasts indefinitely; fetch_err tied to 0.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants (OP_NOOP=000000, OP_JUMP=000001, OP_BEQ=100000, OP_BNE=100001, R-type 0100xx, I-type 11xxxx).
  - PCSrc encodings PCSRC_ALU/PCSRC_ALUOUT/PCSRC_JUMP/PCSRC_HOLD.
  - IR field bit positions.
- Sub-module next_pc_sel: combinational PCSrc mux plus branch-condition evaluation producing next_pc and pc_we.

Test Plan:
- Reset then release; IRWrite=1, PCWrite=1, PCSrc=00, alu_result=1, imem_valid after 2 cycles with 0x48000000 -> stall high for 2 cycles, imem_addr=0 throughout, then ir=0x48000000, opcode=010010, pc=1.
- Zero-wait fetch: imem_valid same cycle as IRWrite -> stall never asserts; ir and pc update on that edge.
- BEQ taken: PCWriteCond=1, BEQ=1, alu_zero=1, PCSrc=01, alu_out=0x0020 -> pc=0x0020. Same inputs with alu_zero=0 -> pc unchanged.
- BNE: BEQ=0, alu_zero=0, alu_out=0x0040 -> pc=0x0040. With alu_zero=1 -> pc unchanged.
- Jump: ir=0x040000FF, PCWrite=1, PCSrc=10 -> pc=0x00FF. Reset asserted during WAIT -> pc=RESET_PC, stall=0, a subsequent imem_valid is ignored.
- FETCH_TIMEOUT_EN: no imem_valid for 15 cycles -> ir=0, opcode=000000, fetch_err=1 held until reset.
